// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared AXI4-Lite response codes, master state encoding and
//               a response-classification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    // Error responses are exactly the codes with bit 1 set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:   err = 1'b0;
            RESP_EXOKAY: err = 1'b0;
            RESP_SLVERR: err = 1'b1;
            RESP_DECERR: err = 1'b1;
            default:     err = 1'b0;
        endcase
        return err;
    endfunction

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_master_stats.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_stats
// Description : Saturating write/read/error transaction counters; only
//               instantiated when AXI4_LITE_MASTER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master_stats
    import axi4_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rsp_enter,
    input  logic        i_is_write,
    input  logic [1:0]  i_resp,
    output logic [15:0] o_wr_count,
    output logic [15:0] o_rd_count,
    output logic [15:0] o_err_count
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;
        if (i_rsp_enter) begin
            if (i_is_write && (wr_count_q != C_CNT_MAX)) begin
                wr_count_d = wr_count_q + 16'd1;
            end
            if (!i_is_write && (rd_count_q != C_CNT_MAX)) begin
                rd_count_d = rd_count_q + 16'd1;
            end
            if (resp_is_err(i_resp) && (err_count_q != C_CNT_MAX)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q  <= 16'd0;
            rd_count_q  <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_wr_count  = wr_count_q;
    assign o_rd_count  = rd_count_q;
    assign o_err_count = err_count_q;

endmodule : axi4_lite_master_stats
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master
// Description : Single-outstanding AXI4-Lite master bridging a simple
//               command/response port. Optional counters under macro
//               AXI4_LITE_MASTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [2:0] PROT  = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [WIDTH-1:0]     cmd_wdata,
    input  logic [WIDTH/8-1:0]   cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [31:0]          awaddr,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [WIDTH-1:0]     wdata,
    output logic [WIDTH/8-1:0]   wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    output logic [31:0]          araddr,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [WIDTH-1:0]     rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [15:0]          stat_wr_count,
    output logic [15:0]          stat_rd_count,
    output logic [15:0]          stat_err_count
);

    localparam logic [31:0] C_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; a channel whose valid is
                // already low has finished its handshake.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d     = RESP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    state_d     = RESP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign awaddr    = addr_q & C_ADDR_ALIGN_MASK;
    assign araddr    = addr_q & C_ADDR_ALIGN_MASK;
    assign awprot    = PROT;
    assign arprot    = PROT;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

`ifdef AXI4_LITE_MASTER_STATS_EN
    logic w_rsp_enter;
    logic w_rsp_is_write;

    assign w_rsp_enter    = (state_d == RESP) && (state_q != RESP);
    assign w_rsp_is_write = (state_q == WR_RESP);

    axi4_lite_master_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .i_rsp_enter (w_rsp_enter),
        .i_is_write  (w_rsp_is_write),
        .i_resp      (rsp_resp_d),
        .o_wr_count  (stat_wr_count),
        .o_rd_count  (stat_rd_count),
        .o_err_count (stat_err_count)
    );
`else
    assign stat_wr_count  = 16'd0;
    assign stat_rd_count  = 16'd0;
    assign stat_err_count = 16'd0;
`endif

endmodule : axi4_lite_master
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_master
// Description : Directed self-checking bench for axi4_lite_master with a
//               small configurable-latency slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;

`ifdef AXI4_LITE_MASTER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] stat_wr_count, stat_rd_count, stat_err_count;

    int aw_delay, w_delay, ar_delay;
    int aw_cnt, w_cnt, ar_cnt;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi4_lite_master #(.WIDTH(32), .PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count),
        .stat_err_count(stat_err_count)
    );

    // Slave: ready after a programmable number of waiting cycles; responses
    // are returned the same cycle the master is ready to take them.
    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid  && (w_cnt  >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);
    assign bvalid  = bready;
    assign rvalid  = rready;

    always @(posedge clk) begin
        aw_cnt <= (rst || !awvalid || awready) ? 0 : aw_cnt + 1;
        w_cnt  <= (rst || !wvalid  || wready)  ? 0 : w_cnt + 1;
        ar_cnt <= (rst || !arvalid || arready) ? 0 : ar_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int n_wr;
        int seen;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; bresp = 2'b00; rresp = 2'b00; rdata = '0;
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        repeat (3) step();

        // Reset state
        chk("rst_valids", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 7'b0);
        chk("rst_payload", {rsp_rdata, rsp_resp}, 34'h0);
        chk("rst_addr", {awaddr, araddr}, 64'h0);
        chk("rst_wdata", {wdata, wstrb}, 36'h0);
        chk("rst_stats", {stat_wr_count, stat_rd_count, stat_err_count}, 48'h0);
        rst = 1'b0;
        step();
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Write 0x10 <- DEADBEEF, slave immediate
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF; bresp = 2'b00;
        step();
        cmd_valid = 1'b0;
        chk("wr1_n1_valids", {awvalid, wvalid, cmd_ready, bready}, 4'b1100);
        chk("wr1_n1_payload", {awaddr, wdata, wstrb}, {32'h10, 32'hDEAD_BEEF, 4'hF});
        step();
        chk("wr1_n2", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        step();
        chk("wr1_n3_rsp", {rsp_valid, bready, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h0});
        chk("wr1_stats", {stat_wr_count, stat_rd_count}, STATS_ON ? {16'd1, 16'd0} : 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr1_done", {rsp_valid, cmd_ready}, 2'b01);

        // Read 0x7, SLVERR; then hold rsp_ready low for 5 cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0007;
        rdata = 32'h1234_5678; rresp = 2'b10;
        step();
        cmd_valid = 1'b0;
        chk("rd_n1", {arvalid, rready, awvalid, cmd_ready}, 4'b1000);
        chk("rd_araddr", araddr, 32'h0000_0004);
        step();
        chk("rd_n2", {arvalid, rready, rsp_valid}, 3'b010);
        step();
        chk("rd_n3_rsp", {rsp_valid, rready, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b10, 32'h1234_5678});
        chk("rd_stats", {stat_rd_count, stat_err_count}, STATS_ON ? {16'd1, 16'd1} : 32'd0);
        rdata = 32'hFFFF_0000; rresp = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_rsp", {rsp_valid, cmd_ready, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b10, 32'h1234_5678});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_release", {rsp_valid, cmd_ready}, 2'b01);

        // Write with awready delayed 3 cycles, wready immediate, EXOKAY
        aw_delay = 3; bresp = 2'b01;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020;
        cmd_wdata = 32'h0102_0304; cmd_wstrb = 4'h3;
        step();
        cmd_valid = 1'b0;
        chk("wr2_n1", {awvalid, wvalid, bready}, 3'b110);
        chk("wr2_n1_wstrb", wstrb, 4'h3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr2_aw_wait", {awvalid, wvalid, bready, awaddr}, {3'b100, 32'h20});
        end
        step();
        chk("wr2_aw_done", {awvalid, wvalid, bready}, 3'b001);
        step();
        chk("wr2_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b01, 32'h0});
        chk("wr2_stats", {stat_wr_count, stat_err_count}, STATS_ON ? {16'd2, 16'd1} : 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        aw_delay = 0;

        // Reset while arvalid is high
        ar_delay = 5;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100;
        step();
        cmd_valid = 1'b0;
        chk("rstmid_arvalid", arvalid, 1'b1);
        step();
        rst = 1'b1;
        step();
        chk("rstmid_valids", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 7'b0);
        chk("rstmid_addr", araddr, 32'h0);
        rst = 1'b0; ar_delay = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_rsp", {rsp_valid, arvalid, rready}, 3'b000);
        end
        chk("rstmid_idle", cmd_ready, 1'b1);
        chk("rstmid_stats", {stat_wr_count, stat_rd_count, stat_err_count}, 48'h0);

        // Back-to-back writes for counter saturation
        n_wr = STATS_ON ? 70000 : 20;
        seen = 0;
        bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040;
        cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < n_wr * 6 + 100; i++) begin
            step();
            if (rsp_valid) begin
                seen++;
                if (seen == n_wr) begin
                    cmd_valid = 1'b0;
                    break;
                end
            end
        end
        cmd_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        chk("sat_responses", seen, n_wr);
        chk("sat_wr_count", stat_wr_count, STATS_ON ? 16'hFFFF : 16'h0);
        chk("sat_other", {stat_rd_count, stat_err_count}, 32'h0);
        chk("sat_idle", {cmd_ready, rsp_valid}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi4_lite_master
`default_nettype wire

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter WIDTH, default 32: AXI data width; only 32 is supported.
REQ-002 SHALL have parameter PROT, default 3'b000: constant value driven on awprot and arprot.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports, command side (name direction width meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  AXI response code
REQ-005 Ports, AXI side: awaddr out 32, awprot out 3, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1, araddr out 32, arprot out 3, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rvalid in 1, rready out 1.
REQ-006 Stats ports: stat_wr_count, stat_rd_count and stat_err_count, each out 16.

Function
REQ-007 SHALL use states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-008 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-009 The accepted cmd_addr, cmd_wdata and cmd_wstrb SHALL be registered; awaddr and araddr SHALL carry the registered address with bits [1:0] forced to 0.
REQ-010 Write accepted in cycle N: awvalid and wvalid SHALL both be 1 from cycle N+1.
- Each valid drops the cycle after its own handshake.
- AW and W handshakes may occur in the same cycle or in either order.
REQ-011 AXI payload SHALL stay stable while the matching valid is 1 and ready is 0; a valid SHALL NOT drop before its handshake.
REQ-012 After both AW and W handshakes: enter WR_RESP with bready=1. On bvalid: capture bresp, set rsp_rdata=0, go to RESP.
REQ-013 Read accepted in cycle N: arvalid=1 from cycle N+1 until arready, then RD_DATA with rready=1. On rvalid: capture rdata and rresp, go to RESP.
REQ-014 In RESP, rsp_valid SHALL be 1 with stable rsp_rdata and rsp_resp until rsp_ready; then return to IDLE.
- A new command is accepted no earlier than the cycle after that return.
REQ-015 Minimum latency from command accept to rsp_valid SHALL be 3 cycles when the slave asserts ready/valid immediately.
REQ-016 Only one transaction SHALL be outstanding at a time; bready and rready SHALL be 0 outside WR_RESP and RD_DATA.
REQ-017 bresp/rresp SHALL be passed through unmodified; SLVERR (2'b10) and DECERR (2'b11) do not alter sequencing.

Reset
REQ-018 While rst=1, all valid/ready outputs SHALL be 0, state SHALL be IDLE, and rsp_rdata, rsp_resp and all address/data outputs SHALL be 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no response; the slave shares rst and is reset together with this block.

Configuration
REQ-020 With macro AXI4_LITE_MASTER_STATS_EN defined: each stats counter SHALL increment on entry to RESP, saturating at 16'hFFFF, and clear on rst.
- stat_wr_count counts writes.
- stat_rd_count counts reads.
- stat_err_count counts responses with resp[1]=1.
REQ-021 Without AXI4_LITE_MASTER_STATS_EN: the stats ports SHALL exist and be tied to 0, and no counter logic SHALL be present.

Structure
REQ-022 Shared package axi4_lite_pkg SHALL hold the RESP_OKAY/EXOKAY/SLVERR/DECERR constants and the state encoding.
REQ-023 Counters SHALL live in sub-module axi4_lite_master_stats, instantiated only under AXI4_LITE_MASTER_STATS_EN.

Verification
REQ-024 Write 0x0000_0010 ← 0xDEAD_BEEF, strb 4'hF, slave ready immediately, bresp=0:
- awvalid/wvalid high at N+1 and drop at N+2.
- rsp_valid at N+3 with resp 0 and rdata 0.
REQ-025 Write with awready delayed 3 cycles and wready immediate:
- wvalid drops after 1 cycle.
- awaddr stays stable until accepted.
- bready rises only after the AW handshake.
REQ-026 Read 0x0000_0007 with rdata=0x1234_5678 and rresp=2'b10:
- araddr = 0x0000_0004.
- rsp_rdata = 0x1234_5678, rsp_resp = 2'b10.
- stat_err_count = 1 (STATS_EN only).
REQ-027 rsp_ready held 0 for 5 cycles: rsp_valid and payload are held, and cmd_ready stays 0 throughout.
REQ-028 rst asserted while arvalid=1: next cycle all valids are 0, state is IDLE, and no rsp_valid is produced.
REQ-029 70000 writes with STATS_EN defined: stat_wr_count saturates at 0xFFFF; without the macro it reads 0.
